// File: rtl/adc_driver.sv
// Single-channel ADC capture buffer: serially configured over GPIO, captures N 128-bit
// beats on a trigger, then drains them to the CPU as 32-bit sample pairs.
module adc_driver #(
    parameter int unsigned GPIO_WIDTH         = 16,
    parameter int unsigned CFG_W              = 32,
    parameter int unsigned TRIGGER_BIT        = 0,
    parameter int unsigned SDATA_BIT          = 1,
    parameter int unsigned RUN_CYCLES_CLK_BIT = 2,
    parameter int unsigned SHIFT_VAL_CLK_BIT  = 3,
    parameter int unsigned MAX_BEATS          = 64
) (
    input  logic                  pl_clk,
    input  logic                  rst,
    input  logic [GPIO_WIDTH-1:0] gpio_ctrl,
    input  logic [127:0]          s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  select_in
);

    localparam int unsigned ADDR_W = $clog2(MAX_BEATS);
    localparam int unsigned BEAT_W = ADDR_W + 1;
    localparam int unsigned WORD_W = BEAT_W + 2;

    typedef enum logic [1:0] {StIdle, StCapture, StReadout} state_e;

    state_e                  state_q, state_d;
    logic [GPIO_WIDTH-1:0]   gpio_q, gpio_prev_q, gpio_rise;
    logic [CFG_W-1:0]        run_cycles_q, shift_val_q;
    logic [BEAT_W-1:0]       beats_q, beats_sat, wr_cnt_q;
    logic [3:0]              shift_q, shift_sat;
    logic [WORD_W-1:0]       rd_cnt_q, total_words;
    logic [127:0]            mem [MAX_BEATS];
    logic [127:0]            shifted, mem_rd;
    logic [31:0]             rd_word;
    logic                    start, store, load;
    logic                    unused_gpio;

    // Only the four control bits are consumed; fold the rest away.
    assign unused_gpio = ^{gpio_q, gpio_prev_q};

    assign s_axis_tready = rst;
    assign gpio_rise     = gpio_q & ~gpio_prev_q;
    assign total_words   = {beats_q, 2'b00};

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            gpio_q       <= '0;
            gpio_prev_q  <= '0;
            run_cycles_q <= '0;
            shift_val_q  <= '0;
        end else begin
            gpio_q      <= gpio_ctrl;
            gpio_prev_q <= gpio_q;
            // LSB-first: each new bit enters at the top and walks down.
            if (select_in && gpio_rise[RUN_CYCLES_CLK_BIT]) begin
                run_cycles_q <= {gpio_q[SDATA_BIT], run_cycles_q[CFG_W-1:1]};
            end
            if (select_in && gpio_rise[SHIFT_VAL_CLK_BIT]) begin
                shift_val_q <= {gpio_q[SDATA_BIT], shift_val_q[CFG_W-1:1]};
            end
        end
    end

    always_comb begin
        beats_sat = (run_cycles_q > CFG_W'(MAX_BEATS)) ? BEAT_W'(MAX_BEATS)
                                                       : run_cycles_q[BEAT_W-1:0];
        shift_sat = (shift_val_q > CFG_W'(15)) ? 4'd15 : shift_val_q[3:0];
    end

    always_comb begin
        shifted = '0;
        for (int k = 0; k < 8; k++) begin
            shifted[16*k +: 16] = $signed(s_axis_tdata[16*k +: 16]) >>> shift_q;
        end
    end

    assign mem_rd = mem[rd_cnt_q[ADDR_W+1:2]];

    always_comb begin
        rd_word = '0;
        case (rd_cnt_q[1:0])
            2'd0:    rd_word = mem_rd[31:0];
            2'd1:    rd_word = mem_rd[63:32];
            2'd2:    rd_word = mem_rd[95:64];
            default: rd_word = mem_rd[127:96];
        endcase
    end

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        store   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gpio_rise[TRIGGER_BIT] && (beats_sat != '0)) begin
                    start   = 1'b1;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (s_axis_tvalid) begin
                    store = 1'b1;
                    if (wr_cnt_q + BEAT_W'(1) == beats_q) begin
                        state_d = StReadout;
                    end
                end
            end
            StReadout: begin
                // Refill the output register whenever it is empty or being drained.
                load = (rd_cnt_q != total_words) && (!m_axis_tvalid || m_axis_tready);
                if (m_axis_tvalid && m_axis_tready && (rd_cnt_q == total_words)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            beats_q       <= '0;
            shift_q       <= '0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (start) begin
                beats_q  <= beats_sat;
                shift_q  <= shift_sat;
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
            end
            if (store) begin
                wr_cnt_q <= wr_cnt_q + BEAT_W'(1);
            end
            if (load) begin
                m_axis_tdata  <= rd_word;
                m_axis_tvalid <= 1'b1;
                rd_cnt_q      <= rd_cnt_q + WORD_W'(1);
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // Buffer contents survive reset; only the pointers are cleared.
    always_ff @(posedge pl_clk) begin
        if (store) begin
            mem[wr_cnt_q[ADDR_W-1:0]] <= shifted;
        end
    end

endmodule

// File: tb/tb_adc_driver.sv
// Directed self-checking bench for adc_driver: config shifting, capture/readout,
// backpressure, sample shifting, select gating and mid-operation events.
module tb_adc_driver;

    logic         pl_clk = 1'b0;
    logic         rst;
    logic [15:0]  gpio_ctrl;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         select_in;

    int           npass = 0;
    int           ntotal = 0;
    logic [31:0]  got [64];
    logic [31:0]  exp_w;
    int           n, bad, first_c, last_c;

    localparam logic [127:0] RampData = {16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                         16'h0005, 16'h0006, 16'h0007, 16'h0008};

    adc_driver dut (
        .pl_clk        (pl_clk),
        .rst           (rst),
        .gpio_ctrl     (gpio_ctrl),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .select_in     (select_in)
    );

    always #5 pl_clk = ~pl_clk;

    task automatic tick();
        @(posedge pl_clk);
        #1;
    endtask

    task automatic shift_cfg(input int clk_bit, input logic [31:0] val);
        for (int i = 0; i < 32; i++) begin
            gpio_ctrl[1] = val[i];
            tick();
            gpio_ctrl[clk_bit] = 1'b1;
            tick();
            tick();
            gpio_ctrl[clk_bit] = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_trigger();
        gpio_ctrl[0] = 1'b1;
        tick();
        tick();
        tick();
        gpio_ctrl[0] = 1'b0;
        tick();
    endtask

    // Runs a fixed window, recording transfers and any change of a stalled word.
    task automatic collect(input int cycles, input bit toggle, output int cnt,
                           output int stall_bad, output int fc, output int lc);
        logic        stalled;
        logic [31:0] held;
        cnt = 0; stall_bad = 0; fc = -1; lc = -1;
        stalled = 1'b0; held = '0;
        for (int c = 0; c < cycles; c++) begin
            m_axis_tready = toggle ? (c % 2 == 0) : 1'b1;
            @(negedge pl_clk);
            if (stalled && (!m_axis_tvalid || m_axis_tdata !== held)) stall_bad++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (cnt < 64) got[cnt] = m_axis_tdata;
                cnt++;
                lc = c;
                if (fc < 0) fc = c;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = m_axis_tdata;
            tick();
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (10) tick();
        ntotal++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0) begin
            $display("FAIL reset_outputs: tvalid=%b tdata=%h required 0/0", m_axis_tvalid,
                     m_axis_tdata);
        end else npass++;
        ntotal++;
        if (s_axis_tready !== 1'b0) begin
            $display("FAIL reset_tready: got %b required 0", s_axis_tready);
        end else npass++;
        rst = 1'b1;
        tick();
        ntotal++;
        if (s_axis_tready !== 1'b1 || dut.state_q !== 2'd0 || dut.run_cycles_q !== 32'd0) begin
            $display("FAIL post_reset: tready=%b state=%0d run=%0d required 1/0/0",
                     s_axis_tready, dut.state_q, dut.run_cycles_q);
        end else npass++;
        shift_cfg(2, 32'd4);
        shift_cfg(3, 32'd0);
        tick();
        ntotal++;
        if (dut.run_cycles_q !== 32'd4) begin
            $display("FAIL cfg_run_cycles: got %0d required 4", dut.run_cycles_q);
        end else npass++;
        ntotal++;
        if (dut.shift_val_q !== 32'd0 || m_axis_tvalid !== 1'b0) begin
            $display("FAIL cfg_shift_val: shift=%0d tvalid=%b required 0/0",
                     dut.shift_val_q, m_axis_tvalid);
        end else npass++;
    endtask

    task automatic test_capture_readout();
        s_axis_tdata  = RampData;
        s_axis_tvalid = 1'b1;
        pulse_trigger();
        repeat (50) tick();
        ntotal++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h00070008) begin
            $display("FAIL cr_first_word_ready: tvalid=%b tdata=%h required 1/00070008",
                     m_axis_tvalid, m_axis_tdata);
        end else npass++;
        collect(40, 1'b0, n, bad, first_c, last_c);
        ntotal++;
        if (n !== 16) begin
            $display("FAIL cr_count: got %0d required 16", n);
        end else npass++;
        ntotal++;
        if (last_c - first_c !== 15) begin
            $display("FAIL cr_rate: span %0d cycles required 15", last_c - first_c);
        end else npass++;
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: exp_w = 32'h00070008;
                1: exp_w = 32'h00050006;
                2: exp_w = 32'h00030004;
                default: exp_w = 32'h00010002;
            endcase
            ntotal++;
            if (got[i] !== exp_w) begin
                $display("FAIL cr_word%0d: got %h required %h", i, got[i], exp_w);
            end else npass++;
        end
        ntotal++;
        if (m_axis_tvalid !== 1'b0 || dut.state_q !== 2'd0) begin
            $display("FAIL cr_end: tvalid=%b state=%0d required 0/0", m_axis_tvalid,
                     dut.state_q);
        end else npass++;
    endtask

    task automatic test_backpressure();
        pulse_trigger();
        repeat (20) tick();
        collect(80, 1'b1, n, bad, first_c, last_c);
        ntotal++;
        if (n !== 16) begin
            $display("FAIL bp_count: got %0d required 16", n);
        end else npass++;
        ntotal++;
        if (bad !== 0) begin
            $display("FAIL bp_stall_stable: %0d unstable stalls required 0", bad);
        end else npass++;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: exp_w = 32'h00070008;
                1: exp_w = 32'h00050006;
                2: exp_w = 32'h00030004;
                default: exp_w = 32'h00010002;
            endcase
            ntotal++;
            if (got[i + 12] !== exp_w) begin
                $display("FAIL bp_word%0d: got %h required %h", i + 12, got[i + 12], exp_w);
            end else npass++;
        end
    endtask

    task automatic test_shift();
        shift_cfg(3, 32'd1);
        shift_cfg(2, 32'd1);
        s_axis_tdata = '0;
        s_axis_tdata[15:0]  = 16'h8000;
        s_axis_tdata[31:16] = 16'h0008;
        pulse_trigger();
        repeat (20) tick();
        collect(20, 1'b0, n, bad, first_c, last_c);
        ntotal++;
        if (n !== 4) begin
            $display("FAIL sh_count: got %0d required 4", n);
        end else npass++;
        ntotal++;
        if (got[0] !== 32'h0004C000) begin
            $display("FAIL sh_word0: got %h required 0004c000", got[0]);
        end else npass++;
        ntotal++;
        if (got[1] !== 32'h00000000) begin
            $display("FAIL sh_word1: got %h required 00000000", got[1]);
        end else npass++;
    endtask

    task automatic test_select_gating();
        select_in = 1'b0;
        shift_cfg(2, 32'd9);
        ntotal++;
        if (dut.run_cycles_q !== 32'd1) begin
            $display("FAIL sel_gated: run_cycles=%0d required 1", dut.run_cycles_q);
        end else npass++;
        select_in = 1'b1;
        shift_cfg(2, 32'd0);
        pulse_trigger();
        collect(30, 1'b0, n, bad, first_c, last_c);
        ntotal++;
        if (n !== 0 || dut.state_q !== 2'd0) begin
            $display("FAIL sel_zero_run: words=%0d state=%0d required 0/0", n, dut.state_q);
        end else npass++;
    endtask

    task automatic test_mid_events();
        int beat;
        shift_cfg(3, 32'd0);
        shift_cfg(2, 32'd4);
        s_axis_tvalid = 1'b0;
        pulse_trigger();
        ntotal++;
        if (dut.state_q !== 2'd1) begin
            $display("FAIL mid_capture_state: got %0d required 1", dut.state_q);
        end else npass++;
        // Odd cycles carry beat k (all samples k+1); gaps carry junk that must be skipped.
        beat = 0;
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 1 && beat < 4) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = {8{16'(beat + 1)}};
                beat++;
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = {8{16'hFFFF}};
            end
            if (i == 4) gpio_ctrl[0] = 1'b1;
            tick();
        end
        gpio_ctrl[0]  = 1'b0;
        s_axis_tvalid = 1'b0;
        collect(30, 1'b0, n, bad, first_c, last_c);
        ntotal++;
        if (n !== 16) begin
            $display("FAIL mid_count: got %0d required 16", n);
        end else npass++;
        for (int b = 0; b < 4; b++) begin
            exp_w = 32'h00010001 * (b + 1);
            ntotal++;
            if (got[4 * b + 3] !== exp_w) begin
                $display("FAIL mid_beat%0d: got %h required %h", b, got[4 * b + 3], exp_w);
            end else npass++;
        end
    endtask

    task automatic test_reset_in_readout();
        s_axis_tdata  = RampData;
        s_axis_tvalid = 1'b1;
        pulse_trigger();
        repeat (20) tick();
        ntotal++;
        if (m_axis_tvalid !== 1'b1) begin
            $display("FAIL rr_pre_valid: got %b required 1", m_axis_tvalid);
        end else npass++;
        rst = 1'b0;
        #1;
        ntotal++;
        if (m_axis_tvalid !== 1'b0 || dut.state_q !== 2'd0) begin
            $display("FAIL rr_abort: tvalid=%b state=%0d required 0/0", m_axis_tvalid,
                     dut.state_q);
        end else npass++;
        tick();
        rst = 1'b1;
        tick();
        shift_cfg(2, 32'd2);
        pulse_trigger();
        repeat (10) tick();
        collect(20, 1'b0, n, bad, first_c, last_c);
        ntotal++;
        if (n !== 8) begin
            $display("FAIL rr_retrigger_count: got %0d required 8", n);
        end else npass++;
        ntotal++;
        if (got[5] !== 32'h00050006) begin
            $display("FAIL rr_retrigger_word5: got %h required 00050006", got[5]);
        end else npass++;
    endtask

    initial begin
        rst           = 1'b0;
        gpio_ctrl     = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        select_in     = 1'b1;
        for (int i = 0; i < 64; i++) got[i] = '0;
        test_reset();
        test_capture_readout();
        test_backpressure();
        test_shift();
        test_select_gating();
        test_mid_events();
        test_reset_in_readout();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
